// File: rtl/cache_bank_arbiter_if.sv
// Requester-side and bank-side signals of one cache bank arbiter instance.
interface cache_bank_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      rwritten;
  logic [NUM_REQ-1:0]        rvalid2;
  logic [DATA_W-1:0]         rdata2;
  logic                      rwritten2;
  logic [ADDR_W-1:0]         bank_addr_a;
  logic [ADDR_W-1:0]         bank_addr_b;
  logic [DATA_W-1:0]         bank_din_a;
  logic [DATA_W-1:0]         bank_din_b;
  logic                      bank_mem_write_a;
  logic                      bank_mem_write_b;
  logic [DATA_W-1:0]         bank_dout_a;
  logic [DATA_W-1:0]         bank_dout_b;
  logic                      bank_written_a;
  logic                      bank_written_b;

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    input  bank_dout_a, bank_dout_b, bank_written_a, bank_written_b,
    output gnt, rvalid, rdata, rwritten, rvalid2, rdata2, rwritten2,
    output bank_addr_a, bank_addr_b, bank_din_a, bank_din_b,
    output bank_mem_write_a, bank_mem_write_b
  );

  modport master (
    output req, req_we, req_addr, req_wdata,
    output bank_dout_a, bank_dout_b, bank_written_a, bank_written_b,
    input  gnt, rvalid, rdata, rwritten, rvalid2, rdata2, rwritten2,
    input  bank_addr_a, bank_addr_b, bank_din_a, bank_din_b,
    input  bank_mem_write_a, bank_mem_write_b
  );
endinterface

// File: rtl/cache_bank_arbiter.sv
// Round-robin arbiter granting up to two compatible requests per cycle onto a
// dual-port bank, returning read data to the owner one cycle later.
module cache_bank_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned ID_W    = 2
) (
  input logic                  clk,
  input logic                  reset,
  cache_bank_arbiter_if.slave  io_bus
);

  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_tag_v_a;
  logic [ID_W-1:0]   r_tag_id_a;
  logic              r_tag_v_b;
  logic [ID_W-1:0]   r_tag_id_b;

  logic [ADDR_W-1:0] w_addr  [NUM_REQ];
  logic [DATA_W-1:0] w_wdata [NUM_REQ];
  logic              w_a_found;
  logic              w_b_found;
  logic [ID_W-1:0]   w_a_id;
  logic [ID_W-1:0]   w_b_id;
  logic [ID_W-1:0]   w_next_ptr;
  logic [NUM_REQ-1:0] w_gnt;

  always_comb begin : unpack
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      w_addr[j]  = io_bus.req_addr[j*ADDR_W +: ADDR_W];
      w_wdata[j] = io_bus.req_wdata[j*DATA_W +: DATA_W];
    end
  end

  // Scan from the pointer; A takes the first requester, B the next non-conflicting one.
  always_comb begin : select
    logic            v_a_found;
    logic            v_b_found;
    logic            v_conf;
    logic [ID_W-1:0] v_a_id;
    logic [ID_W-1:0] v_b_id;
    logic [ID_W-1:0] v_idx;
    logic [ID_W-1:0] v_last;
    int unsigned     v_sum;
    v_a_found = 1'b0;
    v_b_found = 1'b0;
    v_conf    = 1'b0;
    v_a_id    = '0;
    v_b_id    = '0;
    v_idx     = '0;
    v_last    = '0;
    v_sum     = 0;
    w_gnt     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_sum = 32'(r_rr_ptr) + k;
      if (v_sum >= NUM_REQ) v_sum = v_sum - NUM_REQ;
      v_idx  = ID_W'(v_sum);
      v_conf = (w_addr[v_idx] == w_addr[v_a_id]) &&
               (io_bus.req_we[v_idx] || io_bus.req_we[v_a_id]);
      if (!reset && io_bus.req[v_idx]) begin
        if (!v_a_found) begin
          v_a_found    = 1'b1;
          v_a_id       = v_idx;
          v_last       = v_idx;
          w_gnt[v_idx] = 1'b1;
        end else if (!v_b_found && !v_conf) begin
          v_b_found    = 1'b1;
          v_b_id       = v_idx;
          v_last       = v_idx;
          w_gnt[v_idx] = 1'b1;
        end
      end
    end
    v_sum = 32'(v_last) + 1;
    if (v_sum >= NUM_REQ) v_sum = 0;
    w_next_ptr = ID_W'(v_sum);
    w_a_found  = v_a_found;
    w_b_found  = v_b_found;
    w_a_id     = v_a_id;
    w_b_id     = v_b_id;
  end

  // Unselected ports issue a harmless read of address 0.
  always_comb begin : bank_drive
    io_bus.bank_addr_a      = '0;
    io_bus.bank_din_a       = '0;
    io_bus.bank_mem_write_a = 1'b1;
    io_bus.bank_addr_b      = '0;
    io_bus.bank_din_b       = '0;
    io_bus.bank_mem_write_b = 1'b1;
    if (w_a_found) begin
      io_bus.bank_addr_a      = w_addr[w_a_id];
      io_bus.bank_din_a       = w_wdata[w_a_id];
      io_bus.bank_mem_write_a = ~io_bus.req_we[w_a_id];
    end
    if (w_b_found) begin
      io_bus.bank_addr_b      = w_addr[w_b_id];
      io_bus.bank_din_b       = w_wdata[w_b_id];
      io_bus.bank_mem_write_b = ~io_bus.req_we[w_b_id];
    end
  end

  always_ff @(posedge clk) begin : state
    if (reset) begin
      r_rr_ptr   <= '0;
      r_tag_v_a  <= 1'b0;
      r_tag_id_a <= '0;
      r_tag_v_b  <= 1'b0;
      r_tag_id_b <= '0;
    end else begin
      if (w_a_found) r_rr_ptr <= w_next_ptr;
      r_tag_v_a  <= w_a_found && !io_bus.req_we[w_a_id];
      r_tag_id_a <= w_a_id;
      r_tag_v_b  <= w_b_found && !io_bus.req_we[w_b_id];
      r_tag_id_b <= w_b_id;
    end
  end

  // Returns are suppressed while reset is held so nothing escapes the reset cycle.
  always_comb begin : returns
    io_bus.rvalid  = '0;
    io_bus.rvalid2 = '0;
    if (r_tag_v_a && !reset) io_bus.rvalid[r_tag_id_a]  = 1'b1;
    if (r_tag_v_b && !reset) io_bus.rvalid2[r_tag_id_b] = 1'b1;
  end

  assign io_bus.gnt       = w_gnt;
  assign io_bus.rdata     = io_bus.bank_dout_a;
  assign io_bus.rwritten  = io_bus.bank_written_a;
  assign io_bus.rdata2    = io_bus.bank_dout_b;
  assign io_bus.rwritten2 = io_bus.bank_written_b;

endmodule

// File: tb/tb_cache_bank_arbiter.sv
// Directed bench for cache_bank_arbiter: a per-cycle reference model plus
// hand-computed expectations for each scenario.
module tb_cache_bank_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  cache_bank_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

  cache_bank_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .ID_W(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank: registered read data and written flag, writes on active-low strobe.
  logic [DW-1:0] bank_mem [256];
  logic          bank_wr  [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) bank_wr[i] <= 1'b0;
    end else begin
      if (!bus.bank_mem_write_a) begin
        bank_mem[bus.bank_addr_a] <= bus.bank_din_a;
        bank_wr[bus.bank_addr_a]  <= 1'b1;
      end
      if (!bus.bank_mem_write_b) begin
        bank_mem[bus.bank_addr_b] <= bus.bank_din_b;
        bank_wr[bus.bank_addr_b]  <= 1'b1;
      end
    end
    bus.bank_dout_a    <= bank_mem[bus.bank_addr_a];
    bus.bank_written_a <= bank_wr[bus.bank_addr_a];
    bus.bank_dout_b    <= bank_mem[bus.bank_addr_b];
    bus.bank_written_b <= bank_wr[bus.bank_addr_b];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules applied directly to the request vectors.
  int            m_rr;
  logic [DW-1:0] m_mem [256];
  logic          m_wr  [256];
  int            m_pa, m_pb;
  logic [DW-1:0] m_da, m_db;
  logic          m_wa, m_wb;

  always @(negedge clk) begin
    int a, b, i, last;
    logic [AW-1:0] ai, aa;
    logic [3:0] eg, erv, erv2;
    if (reset) begin
      chk("m_rst_gnt", 32'(bus.gnt), 32'h0);
      chk("m_rst_rvalid", 32'({bus.rvalid2, bus.rvalid}), 32'h0);
      chk("m_rst_we", 32'({bus.bank_mem_write_b, bus.bank_mem_write_a}), 32'h3);
      m_rr = 0; m_pa = -1; m_pb = -1;
      for (int k = 0; k < 256; k++) m_wr[k] = 1'b0;
    end else begin
      erv = '0; erv2 = '0;
      if (m_pa >= 0) erv[m_pa] = 1'b1;
      if (m_pb >= 0) erv2[m_pb] = 1'b1;
      chk("m_rvalid", 32'(bus.rvalid), 32'(erv));
      chk("m_rvalid2", 32'(bus.rvalid2), 32'(erv2));
      if (m_pa >= 0) begin
        chk("m_rdata", bus.rdata, m_da);
        chk("m_rwritten", 32'(bus.rwritten), 32'(m_wa));
      end
      if (m_pb >= 0) begin
        chk("m_rdata2", bus.rdata2, m_db);
        chk("m_rwritten2", 32'(bus.rwritten2), 32'(m_wb));
      end
      a = -1; b = -1;
      for (int k = 0; k < NR; k++) begin
        i = (m_rr + k) % NR;
        if (bus.req[i]) begin
          ai = bus.req_addr[i*AW +: AW];
          if (a < 0) a = i;
          else if (b < 0) begin
            aa = bus.req_addr[a*AW +: AW];
            if (!(ai == aa && (bus.req_we[i] || bus.req_we[a]))) b = i;
          end
        end
      end
      eg = '0;
      if (a >= 0) eg[a] = 1'b1;
      if (b >= 0) eg[b] = 1'b1;
      chk("m_gnt", 32'(bus.gnt), 32'(eg));
      if (a >= 0) begin
        chk("m_addr_a", 32'(bus.bank_addr_a), 32'(bus.req_addr[a*AW +: AW]));
        chk("m_din_a", bus.bank_din_a, bus.req_wdata[a*DW +: DW]);
        chk("m_we_a", 32'(bus.bank_mem_write_a), 32'(!bus.req_we[a]));
      end else
        chk("m_idle_a", 32'({bus.bank_mem_write_a, bus.bank_addr_a}) | 32'(bus.bank_din_a != 0), 32'h100);
      if (b >= 0) begin
        chk("m_addr_b", 32'(bus.bank_addr_b), 32'(bus.req_addr[b*AW +: AW]));
        chk("m_din_b", bus.bank_din_b, bus.req_wdata[b*DW +: DW]);
        chk("m_we_b", 32'(bus.bank_mem_write_b), 32'(!bus.req_we[b]));
      end else
        chk("m_idle_b", 32'({bus.bank_mem_write_b, bus.bank_addr_b}) | 32'(bus.bank_din_b != 0), 32'h100);
      m_pa = -1; m_pb = -1;
      if (a >= 0 && !bus.req_we[a]) begin
        m_pa = a; m_da = m_mem[bus.req_addr[a*AW +: AW]]; m_wa = m_wr[bus.req_addr[a*AW +: AW]];
      end
      if (b >= 0 && !bus.req_we[b]) begin
        m_pb = b; m_db = m_mem[bus.req_addr[b*AW +: AW]]; m_wb = m_wr[bus.req_addr[b*AW +: AW]];
      end
      foreach (eg[g]) if (eg[g] && bus.req_we[g]) begin
        m_mem[bus.req_addr[g*AW +: AW]] = bus.req_wdata[g*DW +: DW];
        m_wr[bus.req_addr[g*AW +: AW]]  = 1'b1;
      end
      last = (b >= 0) ? b : a;
      if (a >= 0) m_rr = (last + 1) % NR;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_req();
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    bus.req[i] = 1'b1;
    bus.req_we[i] = we;
    bus.req_addr[i*AW +: AW] = ad;
    bus.req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_req();
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    m_rr = 0; m_pa = -1; m_pb = -1;
    for (int k = 0; k < 256; k++) begin
      bank_mem[k] = {24'hA5A5A5, 8'(k)};
      m_mem[k]    = {24'hA5A5A5, 8'(k)};
      bank_wr[k]  = 1'b0;
      m_wr[k]     = 1'b0;
    end
    reset = 1'b1;
    clr_req();
    do_reset();

    // Idle after reset.
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("idle_gnt", 32'(bus.gnt), 32'h0);
      chk("idle_rvalid", 32'(bus.rvalid), 32'h0);
      chk("idle_we", 32'({bus.bank_mem_write_b, bus.bank_mem_write_a}), 32'h3);
      step();
    end

    // Write then read-back on requester 0.
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
    settle();
    chk("wr_gnt", 32'(bus.gnt), 32'h1);
    chk("wr_we_a", 32'(bus.bank_mem_write_a), 32'h0);
    step();
    clr_req(); set_req(0, 1'b0, 8'h10, 32'h0);
    settle();
    chk("rd_gnt", 32'(bus.gnt), 32'h1);
    chk("rd_we_a", 32'(bus.bank_mem_write_a), 32'h1);
    step();
    clr_req();
    settle();
    chk("raw_rvalid", 32'(bus.rvalid), 32'h1);
    chk("raw_rdata", bus.rdata, 32'hDEADBEEF);
    chk("raw_rwritten", 32'(bus.rwritten), 32'h1);
    step();

    // Two reads of unwritten lines in one cycle.
    do_reset();
    set_req(1, 1'b0, 8'h20, 32'h0);
    set_req(2, 1'b0, 8'h21, 32'h0);
    settle();
    chk("dual_gnt", 32'(bus.gnt), 32'h6);
    step();
    clr_req();
    settle();
    chk("dual_rvalid", 32'(bus.rvalid), 32'h2);
    chk("dual_rvalid2", 32'(bus.rvalid2), 32'h4);
    chk("dual_rdata2", bus.rdata2, 32'hA5A5A521);
    chk("dual_written", 32'({bus.rwritten2, bus.rwritten}), 32'h0);
    step();

    // Two writes to the same line: serialized, last writer wins.
    do_reset();
    set_req(0, 1'b1, 8'h05, 32'h11111111);
    set_req(3, 1'b1, 8'h05, 32'h33333333);
    settle();
    chk("ww_gnt0", 32'(bus.gnt), 32'h1);
    step();
    clr_req(); set_req(3, 1'b1, 8'h05, 32'h33333333);
    settle();
    chk("ww_gnt3", 32'(bus.gnt), 32'h8);
    step();
    clr_req(); set_req(1, 1'b0, 8'h05, 32'h0);
    settle();
    chk("ww_rd_gnt", 32'(bus.gnt), 32'h2);
    step();
    clr_req();
    settle();
    chk("ww_rdata", bus.rdata, 32'h33333333);
    step();
    // Pointer is back at 0 after the req3 grant, then moved to 2 by req1.
    set_req(0, 1'b0, 8'h50, 32'h0);
    set_req(2, 1'b0, 8'h52, 32'h0);
    set_req(3, 1'b0, 8'h53, 32'h0);
    settle();
    chk("ww_ptr_gnt", 32'(bus.gnt), 32'hC);
    step();
    clr_req();
    step();

    // All four read continuously: pairs alternate.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(8'h40 + i), 32'h0);
    for (int c = 0; c < 6; c++) begin
      settle();
      chk("rr_gnt", 32'(bus.gnt), (c % 2 == 0) ? 32'h3 : 32'hC);
      if (c > 0) begin
        chk("rr_rvalid", 32'(bus.rvalid), (c % 2 == 1) ? 32'h1 : 32'h4);
        chk("rr_rvalid2", 32'(bus.rvalid2), (c % 2 == 1) ? 32'h2 : 32'h8);
      end
      step();
    end
    clr_req();
    step();

    // Read/write conflict on B skips to the next requester.
    do_reset();
    set_req(0, 1'b1, 8'h30, 32'hCAFEF00D);
    set_req(1, 1'b0, 8'h30, 32'h0);
    set_req(2, 1'b0, 8'h31, 32'h0);
    settle();
    chk("cf_gnt", 32'(bus.gnt), 32'h5);
    chk("cf_addr_b", 32'(bus.bank_addr_b), 32'h31);
    step();
    clr_req(); set_req(1, 1'b0, 8'h30, 32'h0);
    settle();
    chk("cf_gnt1", 32'(bus.gnt), 32'h2);
    chk("cf_rvalid2", 32'(bus.rvalid2), 32'h4);
    chk("cf_rwritten2", 32'(bus.rwritten2), 32'h0);
    step();
    clr_req();
    set_req(2, 1'b0, 8'h30, 32'h0);
    set_req(3, 1'b0, 8'h30, 32'h0);
    settle();
    chk("cf_rdata", bus.rdata, 32'hCAFEF00D);
    chk("rr_same_gnt", 32'(bus.gnt), 32'hC);
    step();
    clr_req();
    settle();
    chk("rr_same_rv", 32'({bus.rvalid2, bus.rvalid}), 32'h84);
    chk("rr_same_rdata2", bus.rdata2, 32'hCAFEF00D);
    step();

    // Reset right after a read grant kills the return.
    set_req(0, 1'b0, 8'h10, 32'h0);
    settle();
    chk("rst_rd_gnt", 32'(bus.gnt), 32'h1);
    step();
    reset = 1'b1;
    set_req(0, 1'b0, 8'h22, 32'h0);
    settle();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    step();
    reset = 1'b0;
    clr_req();
    settle();
    chk("post_rst_rvalid", 32'({bus.rvalid2, bus.rvalid}), 32'h0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_bank_arbiter.md
Name: cache_bank_arbiter

Overview:
- Shares one dual-port cache bank among NUM_REQ requesters, e.g. PE load/store units.
- Each cycle, picks up to two compatible requests in round-robin order and drives them onto bank ports A and B.
- Tracks in-flight reads and returns read data and the written-to flag to the owning requester one cycle later.
- Sits between the requester crossbar and the bank; one instance per bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, data word width; matches bank data width
- ADDR_W, 8, bank line address width; matches bank address width
- ID_W, 2, requester index width; must equal ceil(log2(NUM_REQ))

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  request valid, one bit per requester
- req_we  in  NUM_REQ  1 = write, 0 = read, per requester
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  combinational grant; request accepted this cycle
- rvalid  out  NUM_REQ  registered; read data valid for requester i
- rdata  out  DATA_W  read data for the requester flagged in rvalid
- rwritten  out  1  line had been written since reset; qualified by rvalid
- rvalid2  out  NUM_REQ  second read return (port B); same timing as rvalid
- rdata2  out  DATA_W  port-B read data
- rwritten2  out  1  port-B written flag
- bank_addr_a / bank_addr_b  out  ADDR_W  bank port address
- bank_din_a / bank_din_b  out  DATA_W  bank write data
- bank_mem_write_a / bank_mem_write_b  out  1  active-LOW write strobe: 0 = write, 1 = read
- bank_dout_a / bank_dout_b  in  DATA_W  bank registered read data
- bank_written_a / bank_written_b  in  1  bank registered written-to flag

Behaviour:
- Registered state:
  - rr_ptr[ID_W-1:0]
  - per-port tag: tag_v, tag_id
- Reset:
  - rr_ptr=0, tag_v=0.
  - Consequently gnt and rvalid/rvalid2 are all 0.
  - rdata/rdata2 pass through bank data; they are don't-care while rvalid is 0.
  - bank_mem_write_a/b are held at 1 (read) during reset; no bank writes occur.
- Selection, combinational, in cycle T:
  - Scan i = rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - First requester with req=1 goes to port A.
  - Next requester with req=1 goes to port B, unless it conflicts with the port-A request.
  - Conflict: same address AND at least one of the two is a write. A conflicting requester is skipped and the scan continues.
  - Two reads to the same address are not a conflict; both are granted.
- Grants:
  - gnt[i]=1 for each selected requester.
  - A requester holds req, we, addr and wdata stable until it sees gnt; gnt never asserts without req.
- Bank drive:
  - Selected port: bank_mem_write = ~we, with address and data from the requester.
  - Unselected port: bank_mem_write=1, address 0, din 0 (harmless read).
- Read latency: exactly 1 cycle.
  - A read granted in T sets tag_v=1, tag_id=i at the edge ending T.
  - In T+1: rvalid[tag_id]=1 (port A) / rvalid2[tag_id]=1 (port B).
  - rdata = bank_dout_a, rwritten = bank_written_a (port B analogously).
- Writes produce no return. Write tag: tag_v=0.
- Pointer update, at each edge with ≥1 grant:
  - rr_ptr = (index of last-granted requester in scan order + 1) mod NUM_REQ.
  - No grants: unchanged.
- Fairness: any requester holding req is granted within NUM_REQ cycles.
- Back-to-back grants to the same requester on consecutive cycles are allowed (new request while a read is returning).
- Reset mid-operation: in-flight tags are cleared; no rvalid follows the reset cycle.
- Simultaneous read and write to different addresses, on A and B: both granted.
- Read-after-write to the same address in consecutive cycles: the read returns the new data (the bank has committed the write).

Test Plan:
- Reset, then req=0 for 3 cycles -> gnt=0, rvalid=0, bank_mem_write_a=b=1.
- Req0 write addr 0x10 data 0xDEADBEEF in T; req0 read 0x10 in T+1 -> gnt[0] both cycles, bank_mem_write_a=0 in T; rvalid[0] in T+2 with rdata=0xDEADBEEF, rwritten=1.
- Req1 reads 0x20 (never written) and req2 reads 0x21 in the same cycle -> gnt=0b0110; next cycle rvalid[1] and rvalid2[2] both set, rwritten=rwritten2=0.
- Req0 and req3 both write addr 0x05, rr_ptr=0 -> only gnt[0]; next cycle gnt[3], rr_ptr=0 after the second grant; final readback equals req3's data.
- All 4 requesters hold read req continuously for 6 cycles, distinct addresses -> grants pairs {0,1},{2,3},{0,1},… ; each requester served every 2 cycles.
- Read granted in T, reset asserted in T+1 -> no rvalid in T+1 or later; gnt=0 during reset.
